// File: rtl/debug_baud_if.sv
// ---------------------------------------------------------------------------
// debug_baud_if
// Signal bundle between the debug baud controller and its neighbours
// (autobaud detector, debug register file, debug UART RX/TX).
//
// Strobe semantics: ab_wr and cfg_wr are single-cycle write strobes. Each one
// qualifies its divisor bus in the same cycle. There is no ready/backpressure.
// A strobe is either accepted in that cycle or dropped.
//
// Signals (direction seen from the controller, i.e. the slave modport):
//   ab_wr     in   autobaud divisor-valid strobe
//   ab_div    in   autobaud divisor [7:0]
//   cfg_wr    in   host divisor write strobe
//   cfg_div   in   host divisor [7:0]
//   cfg_lock  in   level; freezes divisor against autobaud writes / re-arm
//   rx        in   synchronised debug RX line
//   ab_rst_n  out  active-low re-arm reset to the autobaud detector
//   baud_div  out  current divisor [7:0]
//   baud_tick out  one-cycle 16x oversample strobe
//   locked    out  a valid divisor is loaded and the tick is running
//   brk_det   out  one-cycle pulse when a line break is recognised
// ---------------------------------------------------------------------------
interface debug_baud_if;
    logic       ab_wr;
    logic [7:0] ab_div;
    logic       cfg_wr;
    logic [7:0] cfg_div;
    logic       cfg_lock;
    logic       rx;
    logic       ab_rst_n;
    logic [7:0] baud_div;
    logic       baud_tick;
    logic       locked;
    logic       brk_det;

    modport master (
        output ab_wr, ab_div, cfg_wr, cfg_div, cfg_lock, rx,
        input  ab_rst_n, baud_div, baud_tick, locked, brk_det
    );

    modport slave (
        input  ab_wr, ab_div, cfg_wr, cfg_div, cfg_lock, rx,
        output ab_rst_n, baud_div, baud_tick, locked, brk_det
    );
endinterface

// File: rtl/debug_baud_ctrl.sv
// ---------------------------------------------------------------------------
// debug_baud_ctrl
// Owns the debug UART baud divisor. It arbitrates between autobaud and host
// divisor writes. It generates the 16x oversample tick, with a period of
// 2*baud_div clocks. It watches RX for a line break. When a break is seen
// while the divisor is not locked by the host, it pulses the autobaud
// detector's reset so that the rate can be renegotiated.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   bus          slave modport of debug_baud_if (see that file)
//   o_dbg_state  out  current FSM state (0 DETECT, 1 LOCKED, 2 REARM)
// ---------------------------------------------------------------------------
module debug_baud_ctrl #(
    parameter int BRK_TICKS = 320,
    parameter int REARM_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    debug_baud_if.slave        bus,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        ST_DETECT = 2'd0,
        ST_LOCKED = 2'd1,
        ST_REARM  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_baud_div;
    logic [8:0]  r_presc;
    logic [11:0] r_brk_cnt;
    logic [3:0]  r_rearm_cnt;
    logic        r_brk_det;

    logic        w_cfg_ok;
    logic        w_ab_ok;
    logic        w_wr_accept;
    logic [7:0]  w_wr_div;
    logic [8:0]  w_presc_top;
    logic        w_tick;
    logic        w_brk_hit;
    logic        w_rearm_done;

    // Write arbitration. A host write always wins. An autobaud write needs
    // the host lock to be clear and no host write in the same cycle. Zero
    // divisors are treated as no write at all.
    always_comb begin
        w_cfg_ok    = bus.cfg_wr && (bus.cfg_div != 8'd0);
        w_ab_ok     = bus.ab_wr && (bus.ab_div != 8'd0) && !bus.cfg_lock && !bus.cfg_wr;
        w_wr_accept = (r_state != ST_REARM) && (w_cfg_ok || w_ab_ok);
        w_wr_div    = w_cfg_ok ? bus.cfg_div : bus.ab_div;
    end

    // Prescaler terminal count is 2*div-1. The divisor is never zero while
    // LOCKED, so the subtraction cannot wrap.
    assign w_presc_top = {r_baud_div, 1'b0} - 9'd1;
    assign w_tick      = (r_state == ST_LOCKED) && (r_presc == w_presc_top);

    // A break is the BRK_TICKS-th consecutive low tick. A write in the same
    // cycle takes priority: it restarts the monitor and no break is recognised.
    assign w_brk_hit = (r_state == ST_LOCKED) && !w_wr_accept && w_tick && !bus.rx
                       && (r_brk_cnt == 12'(BRK_TICKS - 1));

    assign w_rearm_done = (r_state == ST_REARM) && (r_rearm_cnt == 4'(REARM_CYC - 1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_DETECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_DETECT: begin
                if (w_wr_accept) w_state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (w_wr_accept) begin
                    w_state_nxt = ST_LOCKED;
                end else if (w_brk_hit && !bus.cfg_lock) begin
                    w_state_nxt = ST_REARM;
                end
            end
            ST_REARM: begin
                if (w_rearm_done) w_state_nxt = ST_DETECT;
            end
            default: w_state_nxt = ST_DETECT;
        endcase
    end

    // Datapath: divisor, prescaler, break counter, re-arm timer, brk pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_baud_div  <= 8'd0;
            r_presc     <= 9'd0;
            r_brk_cnt   <= 12'd0;
            r_rearm_cnt <= 4'd0;
            r_brk_det   <= 1'b0;
        end else begin
            r_brk_det <= w_brk_hit;

            if (w_wr_accept) begin
                r_baud_div <= w_wr_div;
            end

            if (w_wr_accept || (r_state != ST_LOCKED) || w_tick) begin
                r_presc <= 9'd0;
            end else begin
                r_presc <= r_presc + 9'd1;
            end

            // Any high RX sample breaks the run of low ticks.
            if (w_wr_accept || (r_state != ST_LOCKED) || bus.rx || w_brk_hit) begin
                r_brk_cnt <= 12'd0;
            end else if (w_tick && (r_brk_cnt != 12'hFFF)) begin
                r_brk_cnt <= r_brk_cnt + 12'd1;
            end

            if (r_state == ST_REARM) begin
                r_rearm_cnt <= r_rearm_cnt + 4'd1;
            end else begin
                r_rearm_cnt <= 4'd0;
            end
        end
    end

    assign bus.baud_div  = r_baud_div;
    assign bus.baud_tick = w_tick;
    assign bus.locked    = (r_state == ST_LOCKED);
    assign bus.ab_rst_n  = (r_state != ST_REARM);
    assign bus.brk_det   = r_brk_det;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_debug_baud_ctrl.sv
// ---------------------------------------------------------------------------
// tb_debug_baud_ctrl
// Directed and randomised stimulus for debug_baud_ctrl. A behavioural
// reference model predicts every output on every cycle. It derives the tick
// from elapsed cycles since the last write, counts low ticks, and times
// re-arm by cycle numbers.
// ---------------------------------------------------------------------------
module tb_debug_baud_ctrl;

    localparam int BRK = 320;
    localparam int RC  = 2;

    localparam int M_DET = 0;
    localparam int M_LCK = 1;
    localparam int M_RA  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    debug_baud_if bus ();

    debug_baud_ctrl #(.BRK_TICKS(BRK), .REARM_CYC(RC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int cyc     = 0;
    int m       = M_DET;
    int exp_div = 0;
    int wr_cyc  = 0;
    int low     = 0;
    int brk_cyc = -10;
    int ra_end  = 0;
    int obs_brk = 0;
    int exp_brk = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m       = M_DET;
        exp_div = 0;
        wr_cyc  = 0;
        low     = 0;
        brk_cyc = -10;
    endtask

    // One clock: check outputs mid-cycle, advance the model with the inputs
    // that the DUT samples at the coming edge, then move past that edge.
    task automatic run_cycle();
        bit t;
        bit cfg_ok;
        bit ab_ok;
        @(negedge clk);
        t = (m == M_LCK) && (((cyc - wr_cyc) % (2 * exp_div)) == 0);
        chk("baud_div",  {24'd0, bus.baud_div}, 32'(exp_div));
        chk("locked",    {31'd0, bus.locked},   {31'd0, (m == M_LCK)});
        chk("ab_rst_n",  {31'd0, bus.ab_rst_n}, {31'd0, (m != M_RA)});
        chk("baud_tick", {31'd0, bus.baud_tick}, {31'd0, t});
        chk("brk_det",   {31'd0, bus.brk_det},  {31'd0, (cyc == brk_cyc + 1)});
        if (bus.brk_det === 1'b1) obs_brk++;

        if (!rst_n) begin
            model_reset();
        end else begin
            cfg_ok = bus.cfg_wr && (bus.cfg_div != 8'd0);
            ab_ok  = bus.ab_wr && (bus.ab_div != 8'd0) && !bus.cfg_lock && !bus.cfg_wr;
            if ((m != M_RA) && (cfg_ok || ab_ok)) begin
                exp_div = cfg_ok ? int'(bus.cfg_div) : int'(bus.ab_div);
                exp_q.push_back(8'(exp_div));
                m      = M_LCK;
                wr_cyc = cyc;
                low    = 0;
            end else if (m == M_LCK) begin
                if (bus.rx) begin
                    low = 0;
                end else if (t) begin
                    low++;
                    if (low == BRK) begin
                        low     = 0;
                        brk_cyc = cyc;
                        exp_brk++;
                        if (!bus.cfg_lock) begin
                            m      = M_RA;
                            ra_end = cyc + RC;
                        end
                    end
                end
            end else if ((m == M_RA) && (cyc == ra_end)) begin
                m = M_DET;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic do_cfg(input logic [7:0] d);
        bus.cfg_wr  = 1'b1;
        bus.cfg_div = d;
        run_cycle();
        bus.cfg_wr  = 1'b0;
        bus.cfg_div = 8'd0;
    endtask

    task automatic do_ab(input logic [7:0] d);
        bus.ab_wr  = 1'b1;
        bus.ab_div = d;
        run_cycle();
        bus.ab_wr  = 1'b0;
        bus.ab_div = 8'd0;
    endtask

    // The divisor on the bus just after an accepted write must match the
    // oldest write that the model has recorded.
    task automatic chk_div_q(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_qempty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {24'd0, bus.baud_div}, {24'd0, e});
        end
    endtask

    initial begin
        int b0;
        int d;
        int len;
        int guard;

        bus.ab_wr    = 1'b0;
        bus.ab_div   = 8'd0;
        bus.cfg_wr   = 1'b0;
        bus.cfg_div  = 8'd0;
        bus.cfg_lock = 1'b0;
        bus.rx       = 1'b1;

        // Reset
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(5);
        chk("rst_div", {24'd0, bus.baud_div}, 32'd0);
        chk("rst_locked", {31'd0, bus.locked}, 32'd0);

        // Autobaud write 0x0C, tick every 24 clocks
        do_ab(8'h0C);
        chk("ab_div_0c", {24'd0, bus.baud_div}, 32'h0C);
        chk("ab_locked", {31'd0, bus.locked}, 32'd1);
        void'(exp_q.pop_front());
        idle(80);

        // Simultaneous writes: host wins
        bus.ab_wr  = 1'b1;
        bus.ab_div = 8'h10;
        do_cfg(8'h08);
        bus.ab_wr  = 1'b0;
        bus.ab_div = 8'd0;
        chk("arb_cfg_wins", {24'd0, bus.baud_div}, 32'h08);
        chk_div_q("arb_q");
        idle(20);

        // Host lock blocks autobaud
        bus.cfg_lock = 1'b1;
        do_ab(8'h20);
        chk("lock_blocks_ab", {24'd0, bus.baud_div}, 32'h08);
        bus.cfg_lock = 1'b0;
        idle(10);

        // Zero divisors ignored
        do_cfg(8'h00);
        do_ab(8'h00);
        chk("zero_div_ignored", {24'd0, bus.baud_div}, 32'h08);
        chk("zero_locked", {31'd0, bus.locked}, 32'd1);
        idle(10);

        // Full break at div 4, unlocked: re-arm then DETECT
        b0 = obs_brk;
        do_cfg(8'd4);
        chk_div_q("brk_div4");
        bus.rx = 1'b0;
        idle(8 * BRK + 20);
        bus.rx = 1'b1;
        chk("brk_count", 32'(obs_brk - b0), 32'd1);
        chk("brk_to_detect", {31'd0, bus.locked}, 32'd0);
        idle(30);

        // rx high once at the 319th tick: no break
        b0 = obs_brk;
        do_cfg(8'd4);
        chk_div_q("nobrk_div4");
        bus.rx = 1'b0;
        idle(8 * (BRK - 1) - 1);
        bus.rx = 1'b1;
        run_cycle();
        bus.rx = 1'b0;
        idle(8 * 100);
        bus.rx = 1'b1;
        chk("nobrk_count", 32'(obs_brk - b0), 32'd0);
        chk("nobrk_locked", {31'd0, bus.locked}, 32'd1);

        // Locked break: pulse only, stays LOCKED
        b0 = obs_brk;
        bus.cfg_lock = 1'b1;
        bus.rx = 1'b0;
        idle(8 * BRK + 20);
        bus.rx = 1'b1;
        bus.cfg_lock = 1'b0;
        chk("lockbrk_count", 32'(obs_brk - b0), 32'd1);
        chk("lockbrk_locked", {31'd0, bus.locked}, 32'd1);
        idle(10);

        // Randomised segments
        for (int s = 0; s < 12; s++) begin
            d = $urandom_range(1, 3);
            bus.cfg_lock = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) do_cfg(8'(d));
            else do_ab(8'(d));
            len = $urandom_range(100, 2 * d * BRK + 40);
            bus.rx = 1'b0;
            for (int i = 0; i < len; i++) begin
                bus.rx = ($urandom_range(0, 499) == 0);
                if ($urandom_range(0, 299) == 0) begin
                    bus.cfg_wr  = 1'($urandom_range(0, 1));
                    bus.cfg_div = 8'($urandom_range(0, 3));
                    bus.ab_wr   = 1'($urandom_range(0, 1));
                    bus.ab_div  = 8'($urandom_range(0, 3));
                end
                run_cycle();
                bus.cfg_wr  = 1'b0;
                bus.cfg_div = 8'd0;
                bus.ab_wr   = 1'b0;
                bus.ab_div  = 8'd0;
            end
            bus.rx = 1'b1;
            bus.cfg_lock = 1'b0;
            idle(10);
        end
        chk("rand_brk_total", 32'(obs_brk), 32'(exp_brk));

        // Reset during REARM
        do_cfg(8'd1);
        bus.rx = 1'b0;
        guard = 0;
        while ((m != M_RA) && (guard < 2000)) begin
            run_cycle();
            guard++;
        end
        chk("reach_rearm", {31'd0, (m == M_RA)}, 32'd1);
        bus.rx = 1'b1;
        rst_n = 1'b0;
        run_cycle();
        rst_n = 1'b1;
        chk("rearm_rst_abn", {31'd0, bus.ab_rst_n}, 32'd1);
        chk("rearm_rst_div", {24'd0, bus.baud_div}, 32'd0);
        chk("rearm_rst_locked", {31'd0, bus.locked}, 32'd0);
        chk("rearm_rst_brk", {31'd0, bus.brk_det}, 32'd0);
        chk("rearm_rst_tick", {31'd0, bus.baud_tick}, 32'd0);
        idle(10);

        // Extreme divisors
        do_cfg(8'd255);
        idle(1100);
        do_cfg(8'd1);
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
